// File: rtl/ifetch_mem_if.sv
// Line-fill bus between the fetch controller and the instruction memory.
interface ifetch_mem_if #(
  parameter int LINE_WORDS = 4
);
  logic                      mem_req_o;
  logic [31:0]               mem_addr_o;
  logic                      mem_ack_i;
  logic [32*LINE_WORDS-1:0]  mem_data_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_data_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_data_i);
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: single-line buffer in front of a multi-cycle
// instruction memory. Hits are served combinationally; a miss stalls the PC
// until the line fill handshake completes.
module ifetch_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        inv_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stall_o,
  output logic [15:0] miss_cnt_o,
  ifetch_mem_if.master mem
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF    = WSEL_W + 2;
  localparam int TAG_W  = 32 - OFF;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                         state, state_nxt;
  logic                           line_valid;
  logic [TAG_W-1:0]               line_tag;
  logic [LINE_WORDS-1:0][31:0]    line_data;
  logic                           discard;
  logic [31:0]                    addr_q;
  logic [15:0]                    miss_cnt_q;
  logic                           hit, miss, fill;

  assign hit          = line_valid && (line_tag == pc_i[31:OFF]);
  assign inst_o       = line_data[pc_i[OFF-1:2]];
  assign inst_valid_o = start_i && hit && (state == IDLE);
  assign stall_o      = start_i && !inst_valid_o;

  assign mem.mem_req_o  = (state == REQ);
  assign mem.mem_addr_o = addr_q;
  assign miss_cnt_o     = miss_cnt_q;

  // Next-state: a miss in IDLE launches a fill; the ack ends it.
  always_comb begin
    state_nxt = state;
    miss      = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: if (start_i && !hit) begin
        miss      = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (mem.mem_ack_i) begin
        fill      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Miss bookkeeping, invalidation and the discard flag for in-flight fills.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      line_valid <= 1'b0;
      discard    <= 1'b0;
      addr_q     <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (miss) begin
        addr_q  <= {pc_i[31:OFF], {OFF{1'b0}}};
        discard <= 1'b0;
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
      if (state == IDLE && inv_i) line_valid <= 1'b0;
      if (state == REQ && !mem.mem_ack_i && inv_i) discard <= 1'b1;
      // An invalidate landing on the ack cycle also discards the line.
      if (fill) begin
        line_valid <= !(discard || inv_i);
        discard    <= 1'b0;
      end
    end
  end

  // Line payload; no reset needed because line_valid qualifies it.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      line_data <= mem.mem_data_i;
      line_tag  <= addr_q[31:OFF];
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, a saturation sequence, and
// a randomized run against a transaction-level model of the line buffer.
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        inv = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst;
  logic        inst_valid, stall;
  logic [15:0] miss_cnt;

  ifetch_mem_if #(.LINE_WORDS(4)) mif ();

  ifetch_ctrl #(.LINE_WORDS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .pc_i        (pc),
    .inv_i       (inv),
    .inst_o      (inst),
    .inst_valid_o(inst_valid),
    .stall_o     (stall),
    .miss_cnt_o  (miss_cnt),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  localparam logic [127:0] LINE0 = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
  localparam logic [127:0] LINE1 = {32'h13, 32'h12, 32'h11, 32'h10};

  // Memory image used by the random run: every word is a function of its address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E3779B1) + 32'h1357;
  endfunction
  function automatic logic [127:0] mkline(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0};
    return {img(b + 32'd12), img(b + 32'd8), img(b + 32'd4), img(b)};
  endfunction

  typedef struct {
    logic        rst, start, inv, ack;
    logic [31:0] pc;
    logic        dsel;
    logic        chk;
    logic        e_valid, e_stall, e_req;
    logic [31:0] e_inst;
    logic [15:0] e_cnt;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic r, s, i, a, input logic [31:0] p, input logic d, c,
                              input logic ev, es, er, input logic [31:0] ei,
                              input logic [15:0] ec, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.start = s; v.inv = i; v.ack = a; v.pc = p; v.dsel = d; v.chk = c;
    v.e_valid = ev; v.e_stall = es; v.e_req = er; v.e_inst = ei; v.e_cnt = ec; v.e_addr = ea;
    return v;
  endfunction

  task automatic drive(input logic r, s, i, a, input logic [31:0] p, input logic [127:0] d);
    @(posedge clk);
    #1;
    rst = r; start = s; inv = i; pc = p;
    mif.mem_ack_i  = a;
    mif.mem_data_i = d;
    #4;
  endtask

  vec_t tbl[34];

  // Model state for the random run
  bit          m_v, m_busy, m_disc, prev_stall;
  logic [27:0] m_tag;
  logic [31:0] m_addr;
  int          m_cnt, wait_n;

  initial begin
    mif.mem_ack_i  = 1'b0;
    mif.mem_data_i = '0;

    //            rst st inv ack pc     ds chk  v  s  r  inst    cnt  addr
    tbl[0]  = mk(0, 1, 0, 0, 32'h08, 0, 0,  0, 0, 0, 0,      0,   0);
    tbl[1]  = mk(0, 1, 0, 0, 32'h08, 0, 1,  0, 1, 0, 0,      0,   0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h08, 0, 1,  0, 1, 0, 0,      0,   0);
    tbl[3]  = mk(1, 1, 0, 0, 32'h08, 0, 1,  0, 1, 1, 0,      1,   0);
    tbl[4]  = mk(1, 1, 0, 0, 32'h08, 0, 1,  0, 1, 1, 0,      1,   0);
    tbl[5]  = mk(1, 1, 0, 0, 32'h08, 0, 1,  0, 1, 1, 0,      1,   0);
    tbl[6]  = mk(1, 1, 0, 1, 32'h08, 0, 1,  0, 1, 1, 0,      1,   0);
    tbl[7]  = mk(1, 1, 0, 0, 32'h08, 0, 1,  1, 0, 0, 32'hC2, 1,   0);
    tbl[8]  = mk(1, 1, 0, 0, 32'h00, 0, 1,  1, 0, 0, 32'hA0, 1,   0);
    tbl[9]  = mk(1, 1, 0, 0, 32'h04, 0, 1,  1, 0, 0, 32'hB1, 1,   0);
    tbl[10] = mk(1, 1, 0, 0, 32'h08, 0, 1,  1, 0, 0, 32'hC2, 1,   0);
    tbl[11] = mk(1, 1, 0, 0, 32'h0C, 0, 1,  1, 0, 0, 32'hD3, 1,   0);
    tbl[12] = mk(1, 1, 0, 0, 32'h10, 0, 1,  0, 1, 0, 0,      1,   0);
    tbl[13] = mk(1, 1, 0, 1, 32'h10, 1, 1,  0, 1, 1, 0,      2,   32'h10);
    tbl[14] = mk(1, 1, 0, 0, 32'h10, 0, 1,  1, 0, 0, 32'h10, 2,   0);
    tbl[15] = mk(1, 1, 0, 0, 32'h0C, 0, 1,  0, 1, 0, 0,      2,   0);
    tbl[16] = mk(1, 1, 1, 0, 32'h0C, 0, 1,  0, 1, 1, 0,      3,   0);
    tbl[17] = mk(1, 1, 0, 1, 32'h0C, 0, 1,  0, 1, 1, 0,      3,   0);
    tbl[18] = mk(1, 1, 0, 0, 32'h0C, 0, 1,  0, 1, 0, 0,      3,   0);
    tbl[19] = mk(1, 1, 0, 1, 32'h0C, 0, 1,  0, 1, 1, 0,      4,   0);
    tbl[20] = mk(1, 1, 0, 0, 32'h0C, 0, 1,  1, 0, 0, 32'hD3, 4,   0);
    tbl[21] = mk(1, 1, 1, 0, 32'h0C, 0, 1,  1, 0, 0, 32'hD3, 4,   0);
    tbl[22] = mk(1, 1, 0, 0, 32'h0C, 0, 1,  0, 1, 0, 0,      4,   0);
    tbl[23] = mk(1, 0, 0, 1, 32'h0C, 0, 1,  0, 0, 1, 0,      5,   0);
    tbl[24] = mk(1, 0, 0, 0, 32'h0C, 0, 1,  0, 0, 0, 0,      5,   0);
    tbl[25] = mk(1, 1, 0, 0, 32'h08, 0, 1,  1, 0, 0, 32'hC2, 5,   0);
    tbl[26] = mk(1, 1, 0, 1, 32'h08, 1, 1,  1, 0, 0, 32'hC2, 5,   0);
    tbl[27] = mk(1, 1, 0, 0, 32'h08, 0, 1,  1, 0, 0, 32'hC2, 5,   0);
    tbl[28] = mk(1, 1, 0, 0, 32'h20, 0, 1,  0, 1, 0, 0,      5,   0);
    tbl[29] = mk(0, 1, 0, 0, 32'h20, 0, 1,  0, 1, 1, 0,      6,   32'h20);
    tbl[30] = mk(1, 0, 0, 1, 32'h20, 1, 1,  0, 0, 0, 0,      0,   0);
    tbl[31] = mk(1, 1, 0, 0, 32'h08, 0, 1,  0, 1, 0, 0,      0,   0);
    tbl[32] = mk(1, 1, 0, 1, 32'h08, 0, 1,  0, 1, 1, 0,      1,   0);
    tbl[33] = mk(1, 1, 0, 0, 32'h08, 0, 1,  1, 0, 0, 32'hC2, 1,   0);

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].inv, tbl[i].ack, tbl[i].pc,
            tbl[i].dsel ? LINE1 : LINE0);
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
        chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
        chk($sformatf("vec%0d req", i), 32'(mif.mem_req_o), 32'(tbl[i].e_req));
        chk($sformatf("vec%0d cnt", i), 32'(miss_cnt), 32'(tbl[i].e_cnt));
        if (tbl[i].e_valid) chk($sformatf("vec%0d inst", i), inst, tbl[i].e_inst);
        if (tbl[i].e_req)   chk($sformatf("vec%0d addr", i), mif.mem_addr_o, tbl[i].e_addr);
      end
    end

    // Saturation: preload the counter close to the top, then force misses by
    // discarding every fill so the same address keeps missing.
    drive(1, 1, 0, 0, 32'h08, LINE0);
    force dut.miss_cnt_q = 16'hFFFA;
    drive(1, 1, 0, 0, 32'h08, LINE0);
    release dut.miss_cnt_q;
    drive(1, 1, 0, 0, 32'h08, LINE0);
    chk("sat preload", 32'(miss_cnt), 32'hFFFA);
    for (int k = 1; k <= 6; k++) begin
      drive(1, 1, 0, 0, 32'h40, LINE1);
      chk($sformatf("sat%0d stall", k), 32'(stall), 32'd1);
      drive(1, 1, 1, 1, 32'h40, LINE1);
      chk($sformatf("sat%0d req", k), 32'(mif.mem_req_o), 32'd1);
      chk($sformatf("sat%0d cnt", k), 32'(miss_cnt), (k >= 5) ? 32'hFFFF : 32'hFFFA + 32'(k));
    end
    drive(1, 1, 0, 0, 32'h40, LINE1);
    chk("sat hold stall", 32'(stall), 32'd1);

    // Randomized run against the transaction-level model.
    drive(0, 0, 0, 0, 32'h0, '0);
    drive(0, 0, 0, 0, 32'h0, '0);
    m_v = 0; m_busy = 0; m_disc = 0; m_cnt = 0; m_addr = 0; m_tag = 0;
    prev_stall = 0; wait_n = 0;
    for (int c = 0; c < 4000; c++) begin
      logic        r_rst, r_start, r_inv, r_ack, hit, e_valid, e_stall;
      logic [31:0] r_pc;
      logic [127:0] r_data;
      r_rst   = ($urandom_range(0, 199) != 0);
      r_start = ($urandom_range(0, 9) != 0);
      r_inv   = ($urandom_range(0, 19) == 0);
      r_pc    = pc;
      if (!m_busy && !prev_stall && $urandom_range(0, 2) == 0)
        r_pc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                            : 32'($urandom_range(0, 63));
      r_data = {$urandom, $urandom, $urandom, $urandom};
      r_ack  = 1'b0;
      if (m_busy) begin
        if (wait_n == 0) begin
          r_ack  = 1'b1;
          r_data = mkline(m_addr);
        end else wait_n--;
      end else r_ack = ($urandom_range(0, 15) == 0);

      drive(r_rst, r_start, r_inv, r_ack, r_pc, r_data);

      hit     = m_v && (m_tag == r_pc[31:4]);
      e_valid = r_start && hit && !m_busy;
      e_stall = r_start && !e_valid;
      chk("rnd valid", 32'(inst_valid), 32'(e_valid));
      chk("rnd stall", 32'(stall), 32'(e_stall));
      chk("rnd req", 32'(mif.mem_req_o), 32'(m_busy));
      chk("rnd cnt", 32'(miss_cnt), 32'(m_cnt));
      if (e_valid) chk("rnd inst", inst, img(r_pc));
      if (m_busy)  chk("rnd addr", mif.mem_addr_o, m_addr);
      prev_stall = e_stall;

      if (!r_rst) begin
        m_v = 0; m_busy = 0; m_disc = 0; m_cnt = 0; m_addr = 0;
      end else if (!m_busy) begin
        if (r_inv) m_v = 0;
        if (r_start && !hit) begin
          m_busy = 1;
          m_disc = 0;
          m_addr = {r_pc[31:4], 4'b0};
          if (m_cnt < 65535) m_cnt++;
          wait_n = $urandom_range(0, 3);
        end
      end else if (r_ack) begin
        m_tag  = m_addr[31:4];
        m_v    = !(m_disc || r_inv);
        m_busy = 0;
        m_disc = 0;
      end else if (r_inv) m_disc = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
